// File: rtl/fc_act_feeder_pkg.sv
// fc_act_feeder_pkg
// Shared types and constants for the fully-connected stage feeder.
//   state_t      : sequencer states
//   BW_PER_ACT   : bits per activation pixel
//   ACT_PER_ADDR : pixels packed per activation SRAM word
//   BW_PER_PARAM : bits per weight
//   FC_OUT_CH    : output channels (weights per weight word)
package fc_act_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BIAS   = 3'd1,
        PRE    = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        WR0    = 3'd5,
        WR1    = 3'd6
    } state_t;

    localparam int BW_PER_ACT   = 12;
    localparam int ACT_PER_ADDR = 4;
    localparam int BW_PER_PARAM = 8;
    localparam int FC_OUT_CH    = 6;

    localparam int ACT_WORD_W = BW_PER_ACT * ACT_PER_ADDR;
    localparam int WGT_WORD_W = BW_PER_PARAM * FC_OUT_CH;

endpackage

// File: rtl/fc_act_feeder_if.sv
// fc_act_feeder_if
// Bus bundle between the feeder, its three SRAMs and the FC stage.
//   act_re/act_raddr/act_rdata : activation SRAM read port (1-cycle latency)
//   wgt_re/wgt_raddr/wgt_rdata : weight/bias SRAM read port (1-cycle latency)
//   f0/weight/bias/fc_enable   : pixel stream to the FC stage
//   out_wen/out_waddr          : output SRAM write strobe
// master = feeder side, slave = memory/FC side.
interface fc_act_feeder_if #(
    parameter int ACT_AW = 10,
    parameter int WGT_AW = 10,
    parameter int OUT_AW = 10
);
    import fc_act_feeder_pkg::*;

    logic                  act_re;
    logic [ACT_AW-1:0]     act_raddr;
    logic [ACT_WORD_W-1:0] act_rdata;
    logic                  wgt_re;
    logic [WGT_AW-1:0]     wgt_raddr;
    logic [WGT_WORD_W-1:0] wgt_rdata;
    logic [BW_PER_ACT-1:0] f0;
    logic [WGT_WORD_W-1:0] weight;
    logic [WGT_WORD_W-1:0] bias;
    logic                  fc_enable;
    logic                  out_wen;
    logic [OUT_AW-1:0]     out_waddr;

    modport master (
        output act_re, act_raddr, wgt_re, wgt_raddr,
        output f0, weight, bias, fc_enable, out_wen, out_waddr,
        input  act_rdata, wgt_rdata
    );

    modport slave (
        input  act_re, act_raddr, wgt_re, wgt_raddr,
        input  f0, weight, bias, fc_enable, out_wen, out_waddr,
        output act_rdata, wgt_rdata
    );

endinterface

// File: rtl/fc_act_feeder_unpack.sv
// fc_pix_unpack
// Picks one 12-bit pixel lane out of a packed 4-pixel activation word
// (lane 0 = most significant pixel) and optionally clamps negatives to 0.
//   word : packed activation word
//   lane : pixel index 0..3
//   pix  : selected pixel
// Optional build macro: FC_ACT_FEEDER_RELU_EN (ReLU on the selected pixel).
module fc_pix_unpack
    import fc_act_feeder_pkg::*;
(
    input  logic [ACT_WORD_W-1:0] word,
    input  logic [1:0]            lane,
    output logic [BW_PER_ACT-1:0] pix
);

    logic [BW_PER_ACT-1:0] raw_s;

    // lane select, pixel 0 sits in the top bits
    always_comb begin
        raw_s = '0;
        case (lane)
            2'd0:    raw_s = word[ACT_WORD_W-1                -: BW_PER_ACT];
            2'd1:    raw_s = word[ACT_WORD_W-1-BW_PER_ACT     -: BW_PER_ACT];
            2'd2:    raw_s = word[ACT_WORD_W-1-2*BW_PER_ACT   -: BW_PER_ACT];
            2'd3:    raw_s = word[ACT_WORD_W-1-3*BW_PER_ACT   -: BW_PER_ACT];
            default: raw_s = '0;
        endcase
    end

    // optional ReLU on the selected pixel
    always_comb begin
`ifdef FC_ACT_FEEDER_RELU_EN
        if (raw_s[BW_PER_ACT-1]) begin
            pix = '0;
        end else begin
            pix = raw_s;
        end
`else
        pix = raw_s;
`endif
    end

endmodule

// File: rtl/fc_act_feeder.sv
// fc_act_feeder
// Sequencer feeding the FC stage: fetches the bias word, then streams
// N_PIXELS activation pixels (one per cycle) with their weight words,
// then issues two output-SRAM write strobes.
//   clk, srst_n : clock, synchronous active-low reset
//   start       : one-cycle start pulse, honoured only in IDLE
//   bus         : SRAM read/write ports and FC stream (fc_act_feeder_if.master)
//   busy        : high outside IDLE
//   done        : one-cycle pulse on return to IDLE
// Optional build macro: FC_ACT_FEEDER_RELU_EN (clamps negative pixels to 0).
//
// Pipeline: the read for pixel k+1 is issued in STREAM cycle k and the
// output registers load pixel k at the end of STREAM cycle k, so the
// visible fc_enable window lags the STREAM state by one cycle. Pixel 0 was
// read in BIAS and parked in the hold registers during PRE.
module fc_act_feeder
    import fc_act_feeder_pkg::*;
#(
    parameter int N_PIXELS  = 48,
    parameter int ACT_AW    = 10,
    parameter int WGT_AW    = 10,
    parameter int OUT_AW    = 10,
    parameter int ACT_BASE  = 0,
    parameter int WGT_BASE  = 0,
    parameter int OUT_BASE  = 0,
    parameter int DRAIN_CYC = 1
) (
    input  logic             clk,
    input  logic             srst_n,
    input  logic             start,
    fc_act_feeder_if.master  bus,
    output logic             busy,
    output logic             done
);

    localparam int KW = $clog2(N_PIXELS);
    localparam int DW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

    state_t                state_r, state_s;
    logic [KW-1:0]         k_r;
    logic [DW-1:0]         drain_r;
    logic                  act_pend_r, wgt_pend_r;
    logic [ACT_WORD_W-1:0] act_hold_r;
    logic [WGT_WORD_W-1:0] wgt_hold_r, bias_r;
    logic [BW_PER_ACT-1:0] f0_r;
    logic [WGT_WORD_W-1:0] weight_r, bias_out_r;
    logic                  fc_enable_r, done_r;

    logic                  act_re_s, wgt_re_s, out_wen_s, last_s;
    logic [ACT_AW-1:0]     act_raddr_s;
    logic [WGT_AW-1:0]     wgt_raddr_s;
    logic [OUT_AW-1:0]     out_waddr_s;
    logic [KW:0]           kp1_s;
    logic [ACT_WORD_W-1:0] act_src_s;
    logic [WGT_WORD_W-1:0] wgt_src_s;
    logic [BW_PER_ACT-1:0] pix_s;

    assign last_s = (k_r == KW'(N_PIXELS - 1));
    assign kp1_s  = {1'b0, k_r} + {{KW{1'b0}}, 1'b1};

    // fresh SRAM data wins; otherwise reuse the word captured earlier
    assign act_src_s = act_pend_r ? bus.act_rdata : act_hold_r;
    assign wgt_src_s = wgt_pend_r ? bus.wgt_rdata : wgt_hold_r;

    fc_pix_unpack u_unpack (
        .word (act_src_s),
        .lane (k_r[1:0]),
        .pix  (pix_s)
    );

    // next-state and SRAM request decode
    always_comb begin
        state_s     = state_r;
        act_re_s    = 1'b0;
        act_raddr_s = '0;
        wgt_re_s    = 1'b0;
        wgt_raddr_s = '0;
        out_wen_s   = 1'b0;
        out_waddr_s = '0;
        case (state_r)
            IDLE: begin
                // a start coinciding with done is dropped
                if (start && !done_r) begin
                    state_s     = BIAS;
                    wgt_re_s    = 1'b1;
                    wgt_raddr_s = WGT_AW'(WGT_BASE) + WGT_AW'(N_PIXELS);
                end else begin
                    state_s = IDLE;
                end
            end
            BIAS: begin
                act_re_s    = 1'b1;
                act_raddr_s = ACT_AW'(ACT_BASE);
                wgt_re_s    = 1'b1;
                wgt_raddr_s = WGT_AW'(WGT_BASE);
                state_s     = PRE;
            end
            PRE: begin
                state_s = STREAM;
            end
            STREAM: begin
                if (!last_s) begin
                    wgt_re_s    = 1'b1;
                    wgt_raddr_s = WGT_AW'(WGT_BASE) + WGT_AW'(kp1_s);
                    // next pixel starts a new packed word
                    if (k_r[1:0] == 2'd3) begin
                        act_re_s    = 1'b1;
                        act_raddr_s = ACT_AW'(ACT_BASE) + ACT_AW'(kp1_s >> 2);
                    end else begin
                        act_re_s = 1'b0;
                    end
                    state_s = STREAM;
                end else begin
                    state_s = DRAIN;
                end
            end
            DRAIN: begin
                // first DRAIN cycle still shows the last registered pixel
                if (drain_r == DW'(DRAIN_CYC)) begin
                    state_s = WR0;
                end else begin
                    state_s = DRAIN;
                end
            end
            WR0: begin
                out_wen_s   = 1'b1;
                out_waddr_s = OUT_AW'(OUT_BASE);
                state_s     = WR1;
            end
            WR1: begin
                out_wen_s   = 1'b1;
                out_waddr_s = OUT_AW'(OUT_BASE) + OUT_AW'(1);
                state_s     = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // state, counters, data capture and registered FC outputs
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state_r     <= IDLE;
            k_r         <= '0;
            drain_r     <= '0;
            act_pend_r  <= 1'b0;
            wgt_pend_r  <= 1'b0;
            act_hold_r  <= '0;
            wgt_hold_r  <= '0;
            bias_r      <= '0;
            f0_r        <= '0;
            weight_r    <= '0;
            bias_out_r  <= '0;
            fc_enable_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            act_pend_r <= act_re_s;
            wgt_pend_r <= wgt_re_s;
            if (act_pend_r) act_hold_r <= bus.act_rdata;
            if (wgt_pend_r) wgt_hold_r <= bus.wgt_rdata;
            if (state_r == BIAS) bias_r <= bus.wgt_rdata;

            if (state_r == PRE) begin
                k_r <= '0;
            end else if (state_r == STREAM) begin
                k_r <= k_r + KW'(1);
            end

            if (state_r == STREAM) begin
                drain_r <= '0;
            end else if (state_r == DRAIN) begin
                drain_r <= drain_r + DW'(1);
            end

            fc_enable_r <= (state_r == STREAM);
            if (state_r == STREAM) begin
                f0_r       <= pix_s;
                weight_r   <= wgt_src_s;
                bias_out_r <= bias_r;
            end
            done_r <= (state_r == WR1);
        end
    end

    assign bus.act_re    = act_re_s;
    assign bus.act_raddr = act_raddr_s;
    assign bus.wgt_re    = wgt_re_s;
    assign bus.wgt_raddr = wgt_raddr_s;
    assign bus.out_wen   = out_wen_s;
    assign bus.out_waddr = out_waddr_s;
    assign bus.f0        = f0_r;
    assign bus.weight    = weight_r;
    assign bus.bias      = bias_out_r;
    assign bus.fc_enable = fc_enable_r;
    assign busy          = (state_r != IDLE);
    assign done          = done_r;

endmodule

// File: tb/tb_fc_act_feeder.sv
// tb_fc_act_feeder
// Self-checking bench for fc_act_feeder with N_PIXELS=8, DRAIN_CYC=1.
// SRAM models answer reads with 1-cycle latency; a negedge monitor logs
// FC beats, reads, writes and done; tasks compare logs against expected
// values pushed when start is driven.
module tb_fc_act_feeder;
    import fc_act_feeder_pkg::*;

    localparam int NP    = 8;
    localparam int DRAIN = 1;

    typedef struct packed {
        logic [11:0] f0;
        logic [47:0] w;
        logic [47:0] b;
    } beat_t;

    logic clk = 1'b0;
    logic srst_n;
    logic start;
    logic busy;
    logic done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [47:0] act_mem [0:3];
    logic [47:0] wgt_mem [0:15];

    beat_t       exp_q[$];
    beat_t       got_q[$];
    int          beat_cyc_q[$];
    logic [9:0]  act_rd_q[$];
    logic [9:0]  wgt_rd_q[$];
    logic [9:0]  wr_q[$];
    int          wr_cyc_q[$];
    int          done_q[$];

    fc_act_feeder_if #(.ACT_AW(10), .WGT_AW(10), .OUT_AW(10)) bus ();

    fc_act_feeder #(.N_PIXELS(NP), .DRAIN_CYC(DRAIN)) dut (
        .clk    (clk),
        .srst_n (srst_n),
        .start  (start),
        .bus    (bus.master),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM models, junk on the bus when not read
    always @(posedge clk) begin
        if (bus.act_re) bus.act_rdata <= act_mem[bus.act_raddr[1:0]];
        else            bus.act_rdata <= 48'hBAD0_BAD1_BAD2;
        if (bus.wgt_re) bus.wgt_rdata <= wgt_mem[bus.wgt_raddr[3:0]];
        else            bus.wgt_rdata <= 48'hDEAD_DEAD_DEAD;
    end

    // monitor: record events only
    always @(negedge clk) begin
        if (bus.fc_enable) begin
            got_q.push_back(beat_t'({bus.f0, bus.weight, bus.bias}));
            beat_cyc_q.push_back(cyc);
        end
        if (bus.act_re)  act_rd_q.push_back(bus.act_raddr);
        if (bus.wgt_re)  wgt_rd_q.push_back(bus.wgt_raddr);
        if (bus.out_wen) begin
            wr_q.push_back(bus.out_waddr);
            wr_cyc_q.push_back(cyc);
        end
        if (done) done_q.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        exp_q.delete(); got_q.delete(); beat_cyc_q.delete();
        act_rd_q.delete(); wgt_rd_q.delete(); wr_q.delete();
        wr_cyc_q.delete(); done_q.delete();
    endtask

    function automatic logic [11:0] exp_pixel(input logic [47:0] w, input int lane);
        logic [11:0] p;
        p = w[47-12*lane -: 12];
`ifdef FC_ACT_FEEDER_RELU_EN
        if (p[11]) p = 12'd0;
`endif
        return p;
    endfunction

    // drive a start pulse and push the expected beat stream
    task automatic start_run();
        for (int k = 0; k < NP; k++)
            exp_q.push_back(beat_t'({exp_pixel(act_mem[k/4], k%4), wgt_mem[k], wgt_mem[NP]}));
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [255:0] outs;
        srst_n = 1'b0;
        start  = 1'b0;
        repeat (3) tick();
        srst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            outs = 256'({bus.act_re, bus.act_raddr, bus.wgt_re, bus.wgt_raddr, bus.f0, bus.weight,
                         bus.bias, bus.fc_enable, bus.out_wen, bus.out_waddr, busy, done});
            n_tests++;
            if (outs !== 256'd0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: outputs=%h expected all zero", i, outs);
            end
        end
    endtask

    task automatic test_stream();
        beat_t e, g;
        int    last_cyc;
        clear_logs();
        tick();
        start_run();
        for (int i = 0; i < 60 && !done; i++) tick();
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_done_timeout: done=%b expected 1", done);
        end
        repeat (2) tick();
        n_tests++;
        if (got_q.size() !== NP) begin
            n_fail++;
            $display("FAIL stream_beat_count: got %0d expected %0d", got_q.size(), NP);
        end
        last_cyc = (beat_cyc_q.size() > 0) ? beat_cyc_q[beat_cyc_q.size()-1] : -100;
        n_tests++;
        if (beat_cyc_q.size() < 1 || (last_cyc - beat_cyc_q[0]) !== NP - 1) begin
            n_fail++;
            $display("FAIL stream_contiguous: span=%0d expected %0d", last_cyc - beat_cyc_q[0], NP - 1);
        end
        for (int k = 0; k < NP; k++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : beat_t'('x);
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL stream_beat%0d: f0=%h w=%h b=%h expected f0=%h w=%h b=%h",
                         k, g.f0, g.w, g.b, e.f0, e.w, e.b);
            end
        end
        n_tests++;
        if (act_rd_q.size() !== 2 || act_rd_q[0] !== 10'd0 || act_rd_q[1] !== 10'd1) begin
            n_fail++;
            $display("FAIL stream_act_reads: count=%0d addrs=%p expected 2 reads at 0,1", act_rd_q.size(), act_rd_q);
        end
        n_tests++;
        if (wgt_rd_q.size() !== NP + 1 || wgt_rd_q[0] !== 10'(NP)) begin
            n_fail++;
            $display("FAIL stream_bias_read: count=%0d first=%0d expected %0d reads, first %0d",
                     wgt_rd_q.size(), wgt_rd_q[0], NP + 1, NP);
        end
        for (int k = 0; k < NP; k++) begin
            n_tests++;
            if (wgt_rd_q[k+1] !== 10'(k)) begin
                n_fail++;
                $display("FAIL stream_wgt_read%0d: addr=%0d expected %0d", k, wgt_rd_q[k+1], k);
            end
        end
        n_tests++;
        if (wr_q.size() !== 2 || wr_q[0] !== 10'd0 || wr_q[1] !== 10'd1) begin
            n_fail++;
            $display("FAIL stream_writes: count=%0d addrs=%p expected 2 writes at 0,1", wr_q.size(), wr_q);
        end
        n_tests++;
        if (wr_cyc_q[0] !== last_cyc + DRAIN + 1 || wr_cyc_q[1] !== last_cyc + DRAIN + 2) begin
            n_fail++;
            $display("FAIL stream_write_timing: wr cycles %0d,%0d expected %0d,%0d",
                     wr_cyc_q[0], wr_cyc_q[1], last_cyc + DRAIN + 1, last_cyc + DRAIN + 2);
        end
        n_tests++;
        if (done_q.size() !== 1 || done_q[0] !== wr_cyc_q[1] + 1) begin
            n_fail++;
            $display("FAIL stream_done_pulse: count=%0d at %0d expected 1 at %0d",
                     done_q.size(), done_q[0], wr_cyc_q[1] + 1);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_busy_after: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_ignore_start();
        beat_t e, g;
        clear_logs();
        start_run();
        for (int i = 0; i < 30 && !bus.fc_enable; i++) tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 60 && !done; i++) tick();
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_done_timeout: done=%b expected 1", done);
        end
        // start in the done cycle must be dropped
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        n_tests++;
        if (got_q.size() !== NP || wr_q.size() !== 2 || done_q.size() !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_no_restart: beats=%0d writes=%0d dones=%0d busy=%b expected %0d,2,1,0",
                     got_q.size(), wr_q.size(), done_q.size(), busy, NP);
        end
        for (int k = 0; k < NP; k++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : beat_t'('x);
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL ignore_beat%0d: f0=%h expected %h", k, g.f0, e.f0);
            end
        end
        // fresh run from IDLE reproduces the sequence
        clear_logs();
        start_run();
        for (int i = 0; i < 60 && !done; i++) tick();
        repeat (2) tick();
        n_tests++;
        if (got_q.size() !== NP || wr_q.size() !== 2 || done_q.size() !== 1) begin
            n_fail++;
            $display("FAIL rerun_counts: beats=%0d writes=%0d dones=%0d expected %0d,2,1",
                     got_q.size(), wr_q.size(), done_q.size(), NP);
        end
        for (int k = 0; k < NP; k++) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : beat_t'('x);
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL rerun_beat%0d: f0=%h w=%h expected f0=%h w=%h", k, g.f0, g.w, e.f0, e.w);
            end
        end
    endtask

    task automatic test_srst_abort();
        logic [255:0] outs;
        clear_logs();
        start_run();
        for (int i = 0; i < 30 && !(bus.fc_enable && got_q.size() == 5); i++) tick();
        n_tests++;
        if (!(bus.fc_enable && got_q.size() == 5)) begin
            n_fail++;
            $display("FAIL srst_reach_k5: beats=%0d fc_enable=%b expected 5 and 1", got_q.size(), bus.fc_enable);
        end
        srst_n = 1'b0;
        tick();
        outs = 256'({bus.act_re, bus.act_raddr, bus.wgt_re, bus.wgt_raddr, bus.f0, bus.weight,
                     bus.bias, bus.fc_enable, bus.out_wen, bus.out_waddr, busy, done});
        n_tests++;
        if (outs !== 256'd0) begin
            n_fail++;
            $display("FAIL srst_outputs: outputs=%h expected all zero", outs);
        end
        srst_n = 1'b1;
        repeat (15) tick();
        n_tests++;
        if (wr_q.size() !== 0 || done_q.size() !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL srst_no_write: writes=%0d dones=%0d busy=%b expected 0,0,0",
                     wr_q.size(), done_q.size(), busy);
        end
    endtask

    initial begin
        act_mem[0] = {12'd1, 12'd2, 12'd3, 12'd4};
        act_mem[1] = {12'hFFF, 12'hFFE, 12'hFFD, 12'hFFC};
        act_mem[2] = 48'h123_456_789_ABC;
        act_mem[3] = 48'h7FF_800_001_FFF;
        for (int i = 0; i < 16; i++)
            wgt_mem[i] = {16'hC0DE, 16'(i * 3 + 7), 16'(i)};
        wgt_mem[NP] = 48'hB1A5_5EED_1234;
        srst_n = 1'b0;
        start  = 1'b0;

        test_reset();
        test_stream();
        test_ignore_start();
        test_srst_abort();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_act_feeder.md
Name: fc_act_feeder

Overview:
- Upstream sequencer for the fully-connected stage.
- Reads packed 4-pixel activation words from activation SRAM and serializes them to one 12-bit pixel per cycle.
- Fetches the matching 6-weight word and the bias word, and holds fc_enable high for exactly N_PIXELS consecutive cycles.
- Then issues the two output-SRAM write strobes (channels 0-3, then channels 4-5).

Parameters:
N_PIXELS, 48, pixels per inference; multiple of 4, range 4..64
ACT_AW, 10, activation SRAM address width
WGT_AW, 10, weight SRAM address width
OUT_AW, 10, output SRAM address width
ACT_BASE, 0, first activation word address
WGT_BASE, 0, first weight word address
OUT_BASE, 0, first output word address
DRAIN_CYC, 1, idle cycles between last streamed pixel and first write strobe

Ports:
clk  in  1  clock
srst_n  in  1  synchronous active-low reset
start  in  1  one-cycle start pulse; ignored unless idle
act_re  out  1  activation SRAM read enable
act_raddr  out  ACT_AW  activation read address
act_rdata  in  48  4 pixels, pixel0 = [47:36], pixel3 = [11:0]; 1-cycle latency
wgt_re  out  1  weight SRAM read enable (same SRAM port carries the bias word)
wgt_raddr  out  WGT_AW  weight/bias read address
wgt_rdata  in  48  6 signed 8-bit weights, ch0 = [47:40]; 1-cycle latency
f0  out  12  signed pixel to FC stage
weight  out  48  weight word to FC stage
bias  out  48  bias word to FC stage
fc_enable  out  1  high during streaming
out_wen  out  1  output SRAM write strobe
out_waddr  out  OUT_AW  output write address
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse after the second write

Behaviour:
- Reset: state IDLE. act_re, wgt_re, fc_enable, out_wen, busy, done = 0. All addresses = 0. f0 = 0, weight = 0, bias = 0.
- States: IDLE -> BIAS -> PRE -> STREAM -> DRAIN -> WR0 -> WR1 -> IDLE.
- IDLE:
  - start=1 -> BIAS.
  - Issue wgt_re=1, wgt_raddr = WGT_BASE + N_PIXELS (bias word sits directly after the weights).
- BIAS (1 cycle):
  - Issue act_re=1 at ACT_BASE and wgt_re=1 at WGT_BASE.
  - The returning bias data is captured into bias_reg at the end of this cycle.
- PRE (1 cycle): no reads issued; data from the BIAS-cycle reads arrives at the end of this cycle and is registered. -> STREAM with k=0.
- STREAM, k = 0..N_PIXELS-1, one pixel per cycle:
  - fc_enable=1.
  - f0 = lane (k mod 4) of the current activation word.
  - weight = weight word for pixel k.
  - bias = bias_reg.
  - f0, weight and bias are registered outputs, so they are aligned in the same cycle.
  - Reads for k+1 are issued so that the data registers in time. Activation is read once per 4 pixels; weight is read every cycle.
  - No read is issued past the last pixel.
  - After k = N_PIXELS-1 -> DRAIN.
- DRAIN: fc_enable=0 for DRAIN_CYC cycles.
- WR0: out_wen=1, out_waddr = OUT_BASE.
- WR1: out_wen=1, out_waddr = OUT_BASE+1. Then done=1 for one cycle, simultaneous with the IDLE entry.
- f0, weight and bias hold their last values outside STREAM.
- start while busy: ignored, with no queueing.
- start in the same cycle as done: ignored; start is sampled only in IDLE.
- srst_n=0 mid-operation: abort at the next edge. All outputs return to reset values and no write strobe is emitted.
- Address counters use full-width binary arithmetic. Any wrap beyond the address width is the integrator's error, not checked.

Optional Feature:
- Macro: FC_ACT_FEEDER_RELU_EN.
- Defined: a negative pixel (f0 bit 11 = 1) is replaced by 0 before the f0 register.
- Undefined: pixels pass through unchanged.
- Timing is identical in both cases.

Decomposition:
- Shared package:
  - state enum (IDLE, BIAS, PRE, STREAM, DRAIN, WR0, WR1)
  - constants BW_PER_ACT=12, ACT_PER_ADDR=4, BW_PER_PARAM=8, FC_OUT_CH=6
  - pixel/weight word widths
- One sub-module: fc_pix_unpack. Selects lane (0..3) from a 48-bit word and applies the optional ReLU.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, busy=0, no SRAM enables.
- N_PIXELS=8, act words {1,2,3,4},{-1,-2,-3,-4}, start at cycle 0 ->
  - f0 sequence 1,2,3,4,-1,-2,-3,-4 on 8 consecutive fc_enable cycles;
  - act reads at ACT_BASE and ACT_BASE+1 only;
  - weight addresses 0..7;
  - bias read at address 8.
- Same run, checking writes -> exactly two out_wen pulses at OUT_BASE, OUT_BASE+1, spaced DRAIN_CYC=1 after the last fc_enable cycle; done pulses once, one cycle after the WR1 write.
- start pulsed during STREAM and in the done cycle -> no restart; the next start from IDLE reproduces the identical sequence.
- srst_n low at k=5 -> next cycle all outputs 0, no out_wen, IDLE.
- With FC_ACT_FEEDER_RELU_EN, the second word -> f0 = 0,0,0,0; without it -> -1,-2,-3,-4.
